// File: rtl/cache_miss_ctrl.sv
// Miss/refill sequencer for one cache way group: PLRU touch on hit,
// victim write-back, line refill, tag write and PLRU touch on miss.
module cache_miss_ctrl #(
   parameter int ASSOC_NUM  = 2,
   parameter int LINE_WORDS = 8,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   input  logic [ADDR_W-1:0]             req_addr,
   input  logic [ASSOC_NUM-1:0]          hit_way,
   input  logic [$clog2(ASSOC_NUM)-1:0]  victim_way,
   input  logic                          victim_dirty,
   input  logic [ADDR_W-1:0]             victim_addr,
   output logic                          plru_update,
   output logic [ASSOC_NUM-1:0]          plru_hit_way,
   output logic                          stall,
   output logic                          wb_req_valid,
   input  logic                          wb_req_ready,
   output logic [ADDR_W-1:0]             wb_req_addr,
   output logic                          wb_data_valid,
   input  logic                          wb_data_ready,
   output logic                          wb_data_last,
   output logic [$clog2(LINE_WORDS)-1:0] arr_rd_idx,
   input  logic [DATA_W-1:0]             arr_rd_data,
   output logic [DATA_W-1:0]             wb_data,
   output logic                          rd_req_valid,
   input  logic                          rd_req_ready,
   output logic [ADDR_W-1:0]             rd_req_addr,
   input  logic                          rd_data_valid,
   input  logic [DATA_W-1:0]             rd_data,
   input  logic                          rd_data_last,
   output logic                          fill_we,
   output logic [$clog2(ASSOC_NUM)-1:0]  fill_way,
   output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
   output logic [DATA_W-1:0]             fill_data,
   output logic                          tag_we,
   output logic                          protocol_err
);

   localparam int WAY_W = $clog2(ASSOC_NUM);
   localparam int CNT_W = $clog2(LINE_WORDS);
   localparam int OFF_W = $clog2(LINE_WORDS * DATA_W / 8);
   localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WB_REQ,
      S_WB_DATA,
      S_RD_REQ,
      S_RD_DATA,
      S_FILL_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [WAY_W-1:0]    r_way;
   logic [ADDR_W-1:0]   r_vaddr;
   logic [ADDR_W-1:0]   r_laddr;
   logic                r_perr;
   logic                w_perr_nxt;
   logic                w_capture;
   logic                w_cnt_last;
   logic [ASSOC_NUM-1:0] w_way_oh;

   assign w_cnt_last   = (r_cnt == CNT_LAST);
   assign w_way_oh     = ASSOC_NUM'(1) << r_way;
   assign protocol_err = r_perr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_way   <= '0;
         r_vaddr <= '0;
         r_laddr <= '0;
         r_perr  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         r_perr  <= w_perr_nxt;
         if (w_capture) begin
            r_way   <= victim_way;
            r_vaddr <= victim_addr;
            r_laddr <= req_addr & LINE_MASK;
         end
      end
   end

   // Every output is forced low while reset is held, even combinational ones.
   always_comb begin
      w_next        = r_state;
      w_cnt_nxt     = r_cnt;
      w_perr_nxt    = r_perr;
      w_capture     = 1'b0;
      plru_update   = 1'b0;
      plru_hit_way  = '0;
      stall         = 1'b0;
      wb_req_valid  = 1'b0;
      wb_req_addr   = '0;
      wb_data_valid = 1'b0;
      wb_data_last  = 1'b0;
      arr_rd_idx    = '0;
      wb_data       = '0;
      rd_req_valid  = 1'b0;
      rd_req_addr   = '0;
      fill_we       = 1'b0;
      fill_way      = '0;
      fill_idx      = '0;
      fill_data     = '0;
      tag_we        = 1'b0;
      if (!reset) begin
         wb_data   = arr_rd_data;
         fill_data = rd_data;
         unique case (r_state)
            S_IDLE: begin
               if (req_valid && (hit_way != '0)) begin
                  plru_update  = 1'b1;
                  plru_hit_way = hit_way;
               end else if (req_valid) begin
                  stall     = 1'b1;
                  w_capture = 1'b1;
                  w_cnt_nxt = '0;
                  w_next    = victim_dirty ? S_WB_REQ : S_RD_REQ;
               end
            end
            S_WB_REQ: begin
               stall        = 1'b1;
               wb_req_valid = 1'b1;
               wb_req_addr  = r_vaddr;
               if (wb_req_ready) begin
                  w_next    = S_WB_DATA;
                  w_cnt_nxt = '0;
               end
            end
            S_WB_DATA: begin
               stall         = 1'b1;
               wb_data_valid = 1'b1;
               arr_rd_idx    = r_cnt;
               wb_data_last  = w_cnt_last;
               if (wb_data_ready) begin
                  w_cnt_nxt = r_cnt + 1'b1;
                  if (w_cnt_last) begin
                     w_next    = S_RD_REQ;
                     w_cnt_nxt = '0;
                  end
               end
            end
            S_RD_REQ: begin
               stall        = 1'b1;
               rd_req_valid = 1'b1;
               rd_req_addr  = r_laddr;
               if (rd_req_ready) begin
                  w_next    = S_RD_DATA;
                  w_cnt_nxt = '0;
               end
            end
            S_RD_DATA: begin
               stall    = 1'b1;
               fill_way = r_way;
               if (rd_data_valid) begin
                  fill_we   = 1'b1;
                  fill_idx  = r_cnt;
                  w_cnt_nxt = r_cnt + 1'b1;
                  // Beat count is ours; a misplaced last flag is only reported.
                  if (rd_data_last != w_cnt_last)
                     w_perr_nxt = 1'b1;
                  if (w_cnt_last) begin
                     tag_we    = 1'b1;
                     w_next    = S_FILL_DONE;
                     w_cnt_nxt = '0;
                  end
               end
            end
            S_FILL_DONE: begin
               stall        = 1'b1;
               plru_update  = 1'b1;
               plru_hit_way = w_way_oh;
               w_next       = S_IDLE;
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Randomized self-checking bench for cache_miss_ctrl (4-way, 8-word lines)
// with a memory/array responder and a transaction-level expectation model.
module tb_cache_miss_ctrl;

   localparam int LW = 8;
   localparam logic [31:0] LINE_BYTES = 32'd32;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [3:0]  hit_way;
   logic [1:0]  victim_way;
   logic        victim_dirty;
   logic [31:0] victim_addr;
   logic        plru_update;
   logic [3:0]  plru_hit_way;
   logic        stall;
   logic        wb_req_valid;
   logic        wb_req_ready;
   logic [31:0] wb_req_addr;
   logic        wb_data_valid;
   logic        wb_data_ready;
   logic        wb_data_last;
   logic [2:0]  arr_rd_idx;
   logic [31:0] arr_rd_data;
   logic [31:0] wb_data;
   logic        rd_req_valid;
   logic        rd_req_ready;
   logic [31:0] rd_req_addr;
   logic        rd_data_valid;
   logic [31:0] rd_data;
   logic        rd_data_last;
   logic        fill_we;
   logic [1:0]  fill_way;
   logic [2:0]  fill_idx;
   logic [31:0] fill_data;
   logic        tag_we;
   logic        protocol_err;

   int n_chk  = 0;
   int n_fail = 0;
   bit perr_model = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] arr_word(input logic [2:0] i);
      return 32'hA5C3_0000 + 32'(i) * 32'h0101_0011;
   endfunction

   assign arr_rd_data = arr_word(arr_rd_idx);

   logic [148:0] all_outs;
   assign all_outs = {plru_update, plru_hit_way, stall, wb_req_valid,
                      wb_req_addr, wb_data_valid, wb_data_last, arr_rd_idx,
                      wb_data, rd_req_valid, rd_req_addr, fill_we, fill_way,
                      fill_idx, fill_data, tag_we, protocol_err};

   cache_miss_ctrl #(
      .ASSOC_NUM (4),
      .LINE_WORDS(LW),
      .ADDR_W    (32),
      .DATA_W    (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .hit_way      (hit_way),
      .victim_way   (victim_way),
      .victim_dirty (victim_dirty),
      .victim_addr  (victim_addr),
      .plru_update  (plru_update),
      .plru_hit_way (plru_hit_way),
      .stall        (stall),
      .wb_req_valid (wb_req_valid),
      .wb_req_ready (wb_req_ready),
      .wb_req_addr  (wb_req_addr),
      .wb_data_valid(wb_data_valid),
      .wb_data_ready(wb_data_ready),
      .wb_data_last (wb_data_last),
      .arr_rd_idx   (arr_rd_idx),
      .arr_rd_data  (arr_rd_data),
      .wb_data      (wb_data),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rd_req_addr  (rd_req_addr),
      .rd_data_valid(rd_data_valid),
      .rd_data      (rd_data),
      .rd_data_last (rd_data_last),
      .fill_we      (fill_we),
      .fill_way     (fill_way),
      .fill_idx     (fill_idx),
      .fill_data    (fill_data),
      .tag_we       (tag_we),
      .protocol_err (protocol_err)
   );

   task automatic set_idle;
      req_valid     = 1'b0;
      req_addr      = '0;
      hit_way       = '0;
      victim_way    = '0;
      victim_dirty  = 1'b0;
      victim_addr   = '0;
      wb_req_ready  = 1'b0;
      wb_data_ready = 1'b0;
      rd_req_ready  = 1'b0;
      rd_data_valid = 1'b0;
      rd_data_last  = 1'b0;
      rd_data       = $urandom;
   endtask

   task automatic test_reset;
      set_idle();
      reset     = 1'b1;
      req_valid = 1'b1;
      hit_way   = 4'b0001;
      rd_data   = 32'hDEAD_BEEF;
      #1;
      n_chk++;
      if (all_outs !== '0) begin
         n_fail++;
         $display("FAIL reset_outs: got %0h want 0", all_outs);
      end
      @(negedge clk);
      reset = 1'b0;
      set_idle();
      #1;
      n_chk++;
      if (stall !== 1'b0 || protocol_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: stall=%b perr=%b want 0 0",
                  stall, protocol_err);
      end
   endtask

   task automatic test_hit;
      logic [3:0] h;
      bit         v;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = $urandom;
      hit_way   = 4'b0100;
      #1;
      n_chk++;
      if (plru_update !== 1'b1 || plru_hit_way !== 4'b0100 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_0100: upd=%b way=%b stall=%b want 1 0100 0",
                  plru_update, plru_hit_way, stall);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         v = ($urandom_range(0, 3) != 0);
         h = 4'b0001 << $urandom_range(0, 3);
         req_valid = v;
         hit_way   = h;
         req_addr  = $urandom;
         #1;
         n_chk++;
         if (plru_update !== v || (v && plru_hit_way !== h) || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_rand: upd=%b way=%b stall=%b want %b %b 0",
                     plru_update, plru_hit_way, stall, v, h);
         end
      end
      @(negedge clk);
      set_idle();
   endtask

   // Drives one miss to completion and checks it at transaction level.
   // wb_mode: 0 always ready, 1 toggling from 1, 2 random.
   task automatic run_miss(input logic [31:0] addr, input int way,
                           input bit dirty, input logic [31:0] vaddr,
                           input int wb_mode, input int rdq_wait,
                           input int last_pos, input bit gaps,
                           input int exp_stall, input int stop_beat,
                           input string nm);
      logic [31:0] line;
      logic [3:0]  oh;
      logic [2:0]  prev_idx;
      int  stall_n = 0, wbh = 0, fills = 0, sent = 0, plru_n = 0;
      int  tags = 0, rdq_seen = 0, wbd_seen = 0, cyc = 0;
      bit  rd_acc = 0, prev_hold = 0, err_pend = 0, done = 0;
      line = addr & ~(LINE_BYTES - 1);
      oh   = 4'b0001 << way;
      @(negedge clk);
      set_idle();
      req_valid    = 1'b1;
      req_addr     = addr;
      victim_way   = 2'(way);
      victim_dirty = dirty;
      victim_addr  = vaddr;
      #1;
      n_chk++;
      if (stall !== 1'b1 || plru_update !== 1'b0) begin
         n_fail++;
         $display("FAIL %s miss_cycle: stall=%b upd=%b want 1 0",
                  nm, stall, plru_update);
      end
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         req_valid     = 1'b1;
         hit_way       = 4'($urandom_range(1, 15));
         req_addr      = $urandom;
         victim_way    = 2'($urandom);
         victim_dirty  = 1'($urandom);
         victim_addr   = $urandom;
         wb_req_ready  = (wb_mode == 2) ? 1'($urandom) : 1'b1;
         wb_data_ready = (wb_mode == 0) ? 1'b1 :
                         (wb_mode == 1) ? (wbd_seen % 2 == 0) : 1'($urandom);
         rd_req_ready  = (rdq_seen >= rdq_wait);
         rd_data_valid = rd_acc && (sent < LW) && (!gaps || 1'($urandom));
         rd_data_last  = rd_data_valid && (sent == last_pos);
         rd_data       = $urandom;
         #1;
         n_chk++;
         if (protocol_err !== (perr_model | err_pend)) begin
            n_fail++;
            $display("FAIL %s perr: got %b want %b", nm, protocol_err,
                     perr_model | err_pend);
         end
         perr_model = perr_model | err_pend;
         err_pend   = 1'b0;
         if (!stall) begin
            done = 1;
            n_chk++;
            if (plru_update !== 1'b1 || plru_hit_way !== hit_way) begin
               n_fail++;
               $display("FAIL %s replay_hit: upd=%b way=%b want 1 %b",
                        nm, plru_update, plru_hit_way, hit_way);
            end
         end else begin
            stall_n++;
         end
         if (wb_req_valid) begin
            n_chk++;
            if (!dirty || wb_req_addr !== vaddr) begin
               n_fail++;
               $display("FAIL %s wb_req: addr=%h want %h dirty=%b",
                        nm, wb_req_addr, vaddr, dirty);
            end
         end
         if (wb_data_valid) begin
            n_chk++;
            if (!dirty || arr_rd_idx !== 3'(wbh) ||
                wb_data_last !== (wbh == LW - 1) ||
                wb_data !== arr_word(3'(wbh)) ||
                (prev_hold && arr_rd_idx !== prev_idx)) begin
               n_fail++;
               $display("FAIL %s wb_beat: idx=%0d last=%b data=%h want %0d %b %h",
                        nm, arr_rd_idx, wb_data_last, wb_data, wbh,
                        wbh == LW - 1, arr_word(3'(wbh)));
            end
            wbd_seen++;
            prev_idx  = arr_rd_idx;
            prev_hold = !wb_data_ready;
            if (wb_data_ready) wbh++;
         end
         if (rd_req_valid) begin
            n_chk++;
            if (rd_req_addr !== line || wbh != (dirty ? LW : 0)) begin
               n_fail++;
               $display("FAIL %s rd_req: addr=%h want %h wb_beats=%0d",
                        nm, rd_req_addr, line, wbh);
            end
            if (rd_req_ready) rd_acc = 1;
            rdq_seen++;
         end
         if (fill_we || rd_data_valid || tag_we) begin
            n_chk++;
            if (fill_we !== rd_data_valid || fill_idx !== 3'(fills) ||
                fill_way !== 2'(way) || fill_data !== rd_data ||
                tag_we !== (fills == LW - 1)) begin
               n_fail++;
               $display("FAIL %s fill: we=%b idx=%0d way=%0d tag=%b want 1 %0d %0d %b",
                        nm, fill_we, fill_idx, fill_way, tag_we, fills, way,
                        fills == LW - 1);
            end
            if (rd_data_valid && (rd_data_last != (fills == LW - 1)))
               err_pend = 1'b1;
            if (tag_we) tags++;
            fills++;
            if (rd_data_valid) sent++;
            if (stop_beat >= 0 && fills - 1 == stop_beat) return;
         end
         if (plru_update && stall) begin
            plru_n++;
            n_chk++;
            if (plru_hit_way !== oh || fills != LW) begin
               n_fail++;
               $display("FAIL %s fill_touch: way=%b want %b fills=%0d",
                        nm, plru_hit_way, oh, fills);
            end
         end
      end
      n_chk++;
      if (!done || wbh != (dirty ? LW : 0) || fills != LW ||
          plru_n != 1 || tags != 1) begin
         n_fail++;
         $display("FAIL %s totals: done=%b wb=%0d fills=%0d touch=%0d tag=%0d",
                  nm, done, wbh, fills, plru_n, tags);
      end
      if (exp_stall >= 0) begin
         n_chk++;
         if (stall_n != exp_stall) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d want %0d",
                     nm, stall_n, exp_stall);
         end
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_clean_miss;
      run_miss(32'h1000_0024, 2, 1'b0, 32'h0, 0, 0, LW - 1, 1'b0,
               10, -1, "clean");
   endtask

   task automatic test_dirty_miss;
      run_miss(32'h3000_1234, 1, 1'b1, 32'h2000_0040, 1, 0, LW - 1, 1'b0,
               26, -1, "dirty");
   endtask

   task automatic test_rd_req_wait;
      run_miss(32'h0000_ABC8, 3, 1'b0, 32'h0, 0, 5, LW - 1, 1'b0,
               15, -1, "rdq_wait");
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++) begin
         run_miss($urandom, $urandom_range(0, 3), 1'($urandom),
                  $urandom & ~(LINE_BYTES - 1), 2, $urandom_range(0, 3),
                  LW - 1, 1'b1, -1, -1, "random");
      end
   endtask

   task automatic test_proto_err;
      run_miss(32'h4000_0100, 0, 1'b0, 32'h0, 0, 0, 3, 1'b0,
               10, -1, "proto");
      n_chk++;
      if (protocol_err !== 1'b1) begin
         n_fail++;
         $display("FAIL proto_sticky: got %b want 1", protocol_err);
      end
   endtask

   task automatic test_reset_mid;
      run_miss(32'h5000_0040, 1, 1'b0, 32'h0, 0, 0, LW - 1, 1'b0,
               -1, 4, "reset_mid");
      reset = 1'b1;
      #1;
      n_chk++;
      if (all_outs !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outs: got %0h want 0", all_outs);
      end
      perr_model = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      set_idle();
      @(negedge clk);
      req_valid = 1'b1;
      hit_way   = 4'b0010;
      #1;
      n_chk++;
      if (plru_update !== 1'b1 || plru_hit_way !== 4'b0010 ||
          stall !== 1'b0 || protocol_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_hit: upd=%b way=%b stall=%b perr=%b want 1 0010 0 0",
                  plru_update, plru_hit_way, stall, protocol_err);
      end
      @(negedge clk);
      set_idle();
   endtask

   initial begin
      test_reset();
      test_hit();
      test_clean_miss();
      test_dirty_miss();
      test_rd_req_wait();
      test_random();
      test_proto_err();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Miss/refill sequencer for one set-associative cache way group (ASSOC_NUM = 2 or 4). It sits beside the tag-compare stage and the pseudo-LRU replacement block. On a hit it issues the PLRU touch. On a miss it does the following:
- stalls the pipeline;
- takes the PLRU victim way;
- writes the victim back if it is dirty;
- refills the line from memory;
- writes the tag;
- touches the PLRU with the refilled way, then releases the stall so the access replays as a hit.

Parameters:
ASSOC_NUM, 2, number of ways; only 2 or 4 are legal.
LINE_WORDS, 8, data words per cache line; must be a power of 2 and at least 2.
ADDR_W, 32, byte address width.
DATA_W, 32, memory and data-array word width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  lookup-stage access valid
req_addr  in  ADDR_W  lookup address
hit_way  in  ASSOC_NUM  one-hot hit vector from tag compare; all zero means miss
victim_way  in  $clog2(ASSOC_NUM)  way chosen by the PLRU block
victim_dirty  in  1  dirty bit of victim_way in the addressed set
victim_addr  in  ADDR_W  line base address of the victim, rebuilt from its tag
plru_update  out  1  PLRU update strobe
plru_hit_way  out  ASSOC_NUM  one-hot way being touched
stall  out  1  pipeline hold
wb_req_valid / wb_req_ready  out / in  1  write-back address handshake
wb_req_addr  out  ADDR_W  victim line base address
wb_data_valid / wb_data_ready  out / in  1  write-back data handshake
wb_data_last  out  1  final write-back beat
arr_rd_idx  out  $clog2(LINE_WORDS)  victim word index to the data array
arr_rd_data  in  DATA_W  data-array word for the same cycle (combinational read)
wb_data  out  DATA_W  equals arr_rd_data
rd_req_valid / rd_req_ready  out / in  1  refill address handshake
rd_req_addr  out  ADDR_W  miss line base address (req_addr with offset bits cleared)
rd_data_valid  in  1  refill beat valid; always accepted, no backpressure
rd_data  in  DATA_W  refill beat
rd_data_last  in  1  memory's last-beat flag
fill_we  out  1  data-array word write enable
fill_way  out  $clog2(ASSOC_NUM)  captured victim way
fill_idx  out  $clog2(LINE_WORDS)  refill word index
fill_data  out  DATA_W  equals rd_data
tag_we  out  1  tag/valid write for fill_way; clears the dirty bit
protocol_err  out  1  sticky; cleared only by reset

Behaviour:
- States: IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL_DONE.
- Reset, asserted at any time including mid-refill: go to IDLE, counters 0, every output 0, protocol_err 0. No partial transfer resumes.
- IDLE, hit (req_valid and hit_way nonzero):
  - plru_update=1 and plru_hit_way=hit_way in the same cycle, combinational.
  - stall=0.
- IDLE, miss (req_valid and hit_way==0):
  - stall=1 in the same cycle, combinational.
  - Register victim_way, victim_addr, victim_dirty and the line address.
  - Next state is WB_REQ if dirty, otherwise RD_REQ.
  - No plru_update.
- stall=1 in every state other than IDLE.
- WB_REQ: wb_req_valid=1 until wb_req_ready. Valid never drops before the handshake. Then go to WB_DATA with beat counter 0.
- WB_DATA:
  - wb_data_valid=1 and arr_rd_idx=counter.
  - The counter advances on valid and ready. Data and index stay stable while ready=0.
  - wb_data_last=1 when counter==LINE_WORDS-1.
  - After the last handshake go to RD_REQ.
- RD_REQ: rd_req_valid=1 until rd_req_ready, then go to RD_DATA with counter 0.
- RD_DATA:
  - On each rd_data_valid: fill_we=1, fill_idx=counter, fill_way=the captured way; the counter increments.
  - On the beat with counter==LINE_WORDS-1: tag_we=1 in the same cycle, then go to FILL_DONE.
  - Beat count is governed by the counter only.
  - rd_data_last on any earlier beat, or missing on the final beat, sets protocol_err. The refill still completes normally.
- FILL_DONE: one cycle with plru_update=1, plru_hit_way=one-hot of the captured way, stall=1. Then go to IDLE. The replayed access hits and produces its own touch.
- Counters wrap modulo LINE_WORDS and are reset to 0 on each state entry.
- No new lookup is accepted outside IDLE. req_valid and hit_way are ignored there.
- Latency, clean miss with zero-wait memory: 1 (RD_REQ) + LINE_WORDS (RD_DATA) + 1 (FILL_DONE) cycles of stall after the miss cycle. A dirty miss adds 1 + LINE_WORDS cycles.

Test Plan:
1. ASSOC_NUM=4, hit_way=4'b0100 in IDLE -> plru_update=1, plru_hit_way=4'b0100, stall=0 in the same cycle; state stays IDLE.
2. Clean miss at req_addr=0x1000_0024, victim_way=2, always-ready memory -> rd_req_addr=0x1000_0020; 8 fill_we pulses with fill_idx 0..7 and fill_way=2; tag_we on beat 7; then one plru_update with 4'b0100; stall high for 10 cycles.
3. Dirty miss, victim_addr=0x2000_0040, wb_data_ready toggling 1,0,1,... -> wb_req_addr=0x2000_0040; exactly 8 wb handshakes with arr_rd_idx 0..7 held through ready=0 cycles; wb_data_last only on idx 7; then refill as in scenario 2.
4. rd_req_ready held 0 for 5 cycles -> rd_req_valid stays 1 and rd_req_addr stays constant; no fill_we until the handshake.
5. rd_data_last asserted on beat 3 of 8 -> protocol_err=1 from the next cycle and stays 1; all 8 beats still written; tag_we on beat 7.
6. reset asserted during RD_DATA beat 4 -> all outputs 0 immediately, asynchronously; after release the controller is in IDLE and a hit gets a same-cycle plru_update.
